// File: rtl/i3c_addr_phase_ctrl.sv
// I3C controller address-phase engine.
// Sends an optional broadcast header (BCAST_ADDR + W) and then the private
// dynamic address + R/W taken from a small dynamic address table (DAT).
// The target ACK is sampled after each address. A NACKed private address is
// retried after a repeated START, up to MAX_RETRY times. All sequencing
// advances only on bit_tick_i, which the bus-level FSM issues once per SCL bit.
`timescale 1ns/1ps

module i3c_addr_phase_ctrl #(
    parameter int unsigned           ADDR_WIDTH  = 7,
    parameter int unsigned           NUM_TARGETS = 4,
    parameter int unsigned           MAX_RETRY   = 2,
    parameter logic [ADDR_WIDTH-1:0] BCAST_ADDR  = 7'h7E,
    localparam int unsigned          IDX_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1,
    localparam int unsigned          RC_W        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [IDX_W-1:0]      target_idx_i,
    input  logic                  is_read_i,
    input  logic                  bcast_en_i,
    input  logic                  dat_we_i,
    input  logic [IDX_W-1:0]      dat_idx_i,
    input  logic [ADDR_WIDTH-1:0] dat_addr_i,
    input  logic                  dat_clr_i,
    input  logic                  bit_tick_i,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  sda_oe_o,
    output logic                  rstart_req_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  acked_o,
    output logic                  nack_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] target_addr_o,
    output logic [RC_W-1:0]       retry_cnt_o
);

    // Bit counter must reach ADDR_WIDTH+1 (one full address + R/W) without wrapping.
    localparam int unsigned CNT_W = $clog2(ADDR_WIDTH + 2);
    localparam int unsigned SW    = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_ADDR,
        ST_HDR_ACK,
        ST_PRIV_ADDR,
        ST_PRIV_ACK,
        ST_RSTART,
        ST_DONE
    } state_e;

    state_e                  state_q;
    logic [SW-1:0]           shreg_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    rw_q;

    logic [ADDR_WIDTH-1:0]   dat_q [NUM_TARGETS];
    logic [NUM_TARGETS-1:0]  dat_vld_q;
    logic [NUM_TARGETS-1:0]  dat_vld_d;

    logic                    entry_valid;
    logic [SW-1:0]           start_word;
    logic [SW-1:0]           priv_word;
    logic [SW-1:0]           bcast_word;

    assign entry_valid = (32'(target_idx_i) < NUM_TARGETS) && dat_vld_q[target_idx_i];
    assign start_word  = {dat_q[target_idx_i], is_read_i};
    // Index and R/W are latched at start, so later DAT writes cannot alter the phase.
    assign priv_word   = {dat_q[idx_q], rw_q};
    assign bcast_word  = {BCAST_ADDR, 1'b0};

    // Next DAT valid vector: a clear wipes everything, then a same-cycle write re-validates its entry.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dat_vld_d = dat_vld_q;
        if (dat_clr_i) begin
            dat_vld_d = '0;
        end
        if (dat_we_i) begin
            dat_vld_d[dat_idx_i] = 1'b1;
        end
    end

    // DAT storage; table updates are frozen while an address phase is in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the DAT is a handful of flops, not a RAM, and must read back as zero after reset, so it is reset like any register.
            dat_vld_q <= '0;
            for (int i = 0; i < NUM_TARGETS; i++) begin
                dat_q[i] <= '0;
            end
        end else if (!busy_o) begin
            dat_vld_q <= dat_vld_d;
            if (dat_we_i) begin
                dat_q[dat_idx_i] <= dat_addr_i;
            end
        end
    end

    // Address-phase FSM with registered bus and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            idx_q         <= '0;
            rw_q          <= 1'b0;
            sda_o         <= 1'b1;
            sda_oe_o      <= 1'b0;
            rstart_req_o  <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            acked_o       <= 1'b0;
            nack_o        <= 1'b0;
            err_o         <= 1'b0;
            target_addr_o <= '0;
            retry_cnt_o   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        idx_q         <= target_idx_i;
                        rw_q          <= is_read_i;
                        target_addr_o <= dat_q[target_idx_i];
                        acked_o       <= 1'b0;
                        nack_o        <= 1'b0;
                        err_o         <= 1'b0;
                        retry_cnt_o   <= '0;
                        bit_cnt_q     <= '0;
                        busy_o        <= 1'b1;
                        if (!entry_valid) begin
                            err_o   <= 1'b1;
                            done_o  <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (bcast_en_i) begin
                            shreg_q  <= bcast_word;
                            sda_oe_o <= 1'b1;
                            sda_o    <= bcast_word[SW-1];
                            state_q  <= ST_HDR_ADDR;
                        end else begin
                            shreg_q  <= start_word;
                            sda_oe_o <= 1'b1;
                            sda_o    <= start_word[SW-1];
                            state_q  <= ST_PRIV_ADDR;
                        end
                    end
                end

                ST_HDR_ADDR, ST_PRIV_ADDR: begin
                    if (bit_tick_i) begin
                        shreg_q   <= {shreg_q[SW-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(ADDR_WIDTH)) begin
                            // Last bit (R/W) just went out: release SDA for the ACK slot.
                            sda_oe_o <= 1'b0;
                            sda_o    <= 1'b1;
                            state_q  <= (state_q == ST_HDR_ADDR) ? ST_HDR_ACK : ST_PRIV_ACK;
                        end else begin
                            sda_o <= shreg_q[SW-2];
                        end
                    end
                end

                ST_HDR_ACK: begin
                    if (bit_tick_i) begin
                        if (!sda_i) begin
                            shreg_q   <= priv_word;
                            bit_cnt_q <= '0;
                            sda_oe_o  <= 1'b1;
                            sda_o     <= priv_word[SW-1];
                            state_q   <= ST_PRIV_ADDR;
                        end else begin
                            nack_o  <= 1'b1;
                            done_o  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_PRIV_ACK: begin
                    if (bit_tick_i) begin
                        if (!sda_i) begin
                            acked_o <= 1'b1;
                            done_o  <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (retry_cnt_o < RC_W'(MAX_RETRY)) begin
                            retry_cnt_o  <= retry_cnt_o + RC_W'(1);
                            shreg_q      <= priv_word;
                            rstart_req_o <= 1'b1;
                            state_q      <= ST_RSTART;
                        end else begin
                            nack_o  <= 1'b1;
                            done_o  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_RSTART: begin
                    // The bus FSM issues Sr during this slot; only the private address follows.
                    if (bit_tick_i) begin
                        rstart_req_o <= 1'b0;
                        bit_cnt_q    <= '0;
                        sda_oe_o     <= 1'b1;
                        sda_o        <= shreg_q[SW-1];
                        state_q      <= ST_PRIV_ADDR;
                    end
                end

                ST_DONE: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    sda_oe_o     <= 1'b0;
                    sda_o        <= 1'b1;
                    rstart_req_o <= 1'b0;
                    done_o       <= 1'b0;
                    busy_o       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/i3c_addr_phase_ctrl.md
Name: i3c_addr_phase_ctrl

Overview:
Controller-side I3C address-phase engine. Serialises an optional broadcast header (7'h7E + W), then a private dynamic address + R/W bit taken from a small on-chip dynamic address table (DAT), and samples the target ACK after each. On NACK it requests a repeated START and retries the private address up to MAX_RETRY times. It sits between the bus-level FSM, which generates SCL timing and START/Sr, and the data-phase logic.

Parameters:
ADDR_WIDTH, 7, width of the dynamic/broadcast address
NUM_TARGETS, 4, number of DAT entries
IDX_W, $clog2(NUM_TARGETS), DAT index width (localparam)
MAX_RETRY, 2, retries of the private address after NACK (0 = no retry)
BCAST_ADDR, 7'h7E, broadcast header address

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  single-cycle request to run an address phase; sampled only in IDLE
target_idx_i  in  IDX_W  DAT index of the target, captured on start_i
is_read_i  in  1  R/W bit for the private address (1 = read), captured on start_i
bcast_en_i  in  1  send 7'h7E/W header before the private address, captured on start_i
dat_we_i  in  1  DAT write strobe; ignored while busy_o=1
dat_idx_i  in  IDX_W  DAT write index
dat_addr_i  in  ADDR_WIDTH  DAT write data; the entry is marked valid
dat_clr_i  in  1  invalidate all DAT entries; ignored while busy_o=1
bit_tick_i  in  1  one-cycle strobe per SCL bit slot, from the bus FSM
sda_i  in  1  sampled SDA
sda_o  out  1  SDA drive value
sda_oe_o  out  1  SDA output enable
rstart_req_o  out  1  repeated-START request to the bus FSM
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle completion pulse
acked_o  out  1  private address ACKed; held until the next accepted start_i
nack_o  out  1  final NACK (header, or private address after retries exhausted); held likewise
err_o  out  1  start_i issued to an invalid DAT entry; held likewise
target_addr_o  out  ADDR_WIDTH  address of the current/last private phase
retry_cnt_o  out  $clog2(MAX_RETRY+1)  retries consumed in the current/last phase

Behaviour:
- Reset: state IDLE, all DAT valid bits 0, DAT data 0, sda_o=1, sda_oe_o=0, every other output 0.
- Sequencing is on bit_tick_i only. Between ticks, state and shift register hold.
- States: IDLE, HDR_ADDR, HDR_ACK, PRIV_ADDR, PRIV_ACK, RSTART, DONE.
- IDLE + start_i:
  - Entry invalid: go to DONE with err_o=1. No SDA activity.
  - Else, with bcast_en_i=1: load {BCAST_ADDR,1'b0} and go to HDR_ADDR.
  - Else: load {DAT[idx],is_read_i} and go to PRIV_ADDR.
  - In every case clear acked_o, nack_o, err_o and retry_cnt_o on acceptance. Load target_addr_o=DAT[idx] (load it also on the invalid-entry path).
- *_ADDR states:
  - sda_oe_o=1 and sda_o=shreg MSB (MSB first).
  - Each tick shifts left and increments the bit counter.
  - On the (ADDR_WIDTH+1)th tick, move to the matching *_ACK state in that same cycle.
- *_ACK states:
  - sda_oe_o=0, sda_o=1.
  - On a tick, sample sda_i (0 = ACK).
- HDR_ACK:
  - ACK: load {DAT[idx],R/W} and go to PRIV_ADDR.
  - NACK: nack_o=1 and go to DONE. The header is not retried.
- PRIV_ACK:
  - ACK: acked_o=1 and go to DONE.
  - NACK with retry_cnt_o<MAX_RETRY: increment retry_cnt_o, reload {DAT[idx],R/W}, go to RSTART.
  - NACK with retries exhausted: nack_o=1 and go to DONE.
- RSTART: rstart_req_o=1 and sda_oe_o=0. On a tick, go to PRIV_ADDR. The header is not resent.
- DONE: lasts one cycle, done_o=1, then IDLE. Total latency from the accepted start_i to done_o is 1 cycle after the final ACK tick.
- Simultaneous events:
  - start_i outside IDLE is ignored.
  - dat_we_i and dat_clr_i in the same cycle: clear takes priority, then the write is applied. The written entry ends up valid.
  - The DAT index and R/W are latched, so DAT writes cannot corrupt a phase.
- Async reset mid-phase returns to reset values immediately and releases SDA (sda_oe_o=0).
- ADDR_WIDTH+1 bits per address. The counter must hold ADDR_WIDTH+1 without wrap.

Test Plan:
- Reset values: assert rst_ni low mid-PRIV_ADDR -> sda_oe_o=0, busy_o=0, all DAT valid bits 0.
- Private read, no header: DAT[1]=7'h12, start idx=1, read=1, bcast_en=0 -> SDA bits 0,0,1,0,0,1,0,1 over 8 ticks; ACK on tick 9 -> done_o pulses, acked_o=1, target_addr_o=7'h12, retry_cnt_o=0.
- Header then write: DAT[0]=7'h3A, bcast_en=1, read=0 -> bits 1,1,1,1,1,1,0,0, ACK, then 0,1,1,1,0,1,0,0, ACK -> acked_o=1 after 18 ticks.
- Retry: DAT[2]=7'h55, MAX_RETRY=2, target NACKs twice then ACKs -> rstart_req_o asserted twice, header not repeated, acked_o=1, retry_cnt_o=2.
- Exhausted retries and header NACK:
  - NACK every private ACK slot -> nack_o=1 after the 3rd NACK, retry_cnt_o=2.
  - Separately, NACK the header -> nack_o=1 with no private bits sent.
- Invalid entry and DAT rules:
  - After dat_clr_i, start idx=3 -> err_o=1 and done_o 1 cycle later, with sda_oe_o never high.
  - dat_we_i while busy_o=1 -> DAT unchanged.
